// File: rtl/wrf_pkt_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wrf_pkt_gen : WR-fabric Ethernet frame generator, 16-bit pipelined WB source
// Revision    : 1.0
// ----------------------------------------------------------------------------
module wrf_pkt_gen #(
    parameter int g_min_len = 64,
    parameter int g_max_len = 1500
) (
    input  logic        clk_sys_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic [10:0] len_i,
    input  logic [15:0] nframes_i,
    input  logic [7:0]  gap_i,
    output logic        busy_o,
    output logic [31:0] frames_sent_o,
    output logic        err_o,
    output logic        src_cyc_o,
    output logic        src_stb_o,
    output logic        src_we_o,
    output logic [1:0]  src_sel_o,
    output logic [1:0]  src_adr_o,
    output logic [15:0] src_dat_o,
    input  logic        src_ack_i,
    input  logic        src_stall_i,
    input  logic        src_err_i
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_PAY   = 3'd2,
        S_DRAIN = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t      state_q;
    logic [10:0] len_q;
    logic [8:0]  qlen_q;
    logic [8:0]  rem_q;
    logic [1:0]  quart_q;
    logic [2:0]  hidx_q;
    logic [9:0]  pidx_q;
    logic [3:0]  outst_q;
    logic [3:0]  outst_d;
    logic [15:0] nframes_q;
    logic [15:0] done_q;
    logic [15:0] done_d;
    logic [7:0]  gap_q;
    logic [31:0] sent_q;
    logic        err_q;
    logic        ferr_q;
    logic        stop_q;

    logic [10:0] len_m;
    logic [10:0] len_eff;
    logic        in_frame;
    logic        cyc;
    logic        stb;
    logic        accept;
    logic        resp;
    logic        pay_last;
    logic        go_drain;
    logic        finish;
    logic        run_done;
    logic        load;
    logic [15:0] dat;

    always_comb begin
        len_m = len_i & 11'h7FC;
        if (len_m < 11'(g_min_len))
            len_eff = 11'(g_min_len);
        else if (len_m > 11'(g_max_len))
            len_eff = 11'(g_max_len);
        else
            len_eff = len_m;
    end

    assign in_frame = (state_q == S_HDR) || (state_q == S_PAY);
    assign cyc      = in_frame || (state_q == S_DRAIN);
    assign stb      = in_frame && (outst_q != 4'hF);
    assign accept   = stb && !src_stall_i;
    assign resp     = cyc && (src_ack_i || src_err_i) && (outst_q != 4'd0);

    always_comb begin
        outst_d = outst_q;
        if (accept && !resp)
            outst_d = outst_q + 4'd1;
        else if (!accept && resp)
            outst_d = outst_q - 4'd1;
    end

    assign pay_last = (state_q == S_PAY) && (pidx_q == len_q[10:1] - 10'd1);
    assign go_drain = in_frame && (src_err_i || (accept && pay_last));
    // Skip DRAIN entirely when the last response lands with the last word.
    assign finish   = (go_drain || (state_q == S_DRAIN)) && (outst_d == 4'd0);
    assign done_d   = done_q + 16'd1;
    assign run_done = (nframes_q != 16'd0) && (done_d == nframes_q);
    assign load     = ((state_q == S_IDLE) && start_i) ||
                      ((state_q == S_GAP) && (gap_q == 8'd0));

    // Payload bytes are quarter indices; the second byte rolls over mid-word
    // when only one byte of the current quarter remains.
    always_comb begin
        dat = 16'h0000;
        if (state_q == S_HDR) begin
            case (hidx_q)
                3'd0, 3'd1, 3'd2: dat = 16'hFFFF;
                3'd3:             dat = 16'h0102;
                3'd4:             dat = 16'h0304;
                3'd5:             dat = 16'h0506;
                default:          dat = {5'd0, len_q};
            endcase
        end else if (state_q == S_PAY) begin
            dat = {6'd0, quart_q, 6'd0, (rem_q == 9'd1) ? quart_q + 2'd1 : quart_q};
        end
    end

    always_ff @(posedge clk_sys_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            qlen_q    <= '0;
            rem_q     <= '0;
            quart_q   <= '0;
            hidx_q    <= '0;
            pidx_q    <= '0;
            outst_q   <= '0;
            nframes_q <= '0;
            done_q    <= '0;
            gap_q     <= '0;
            sent_q    <= '0;
            err_q     <= 1'b0;
            ferr_q    <= 1'b0;
            stop_q    <= 1'b0;
        end else begin
            outst_q <= outst_d;
            if (cyc && src_err_i) begin
                err_q  <= 1'b1;
                ferr_q <= 1'b1;
            end
            if ((state_q != S_IDLE) && stop_i)
                stop_q <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        nframes_q <= nframes_i;
                        done_q    <= '0;
                        err_q     <= 1'b0;
                        stop_q    <= 1'b0;
                    end
                end
                S_HDR: begin
                    if (accept) begin
                        hidx_q <= hidx_q + 3'd1;
                        if (hidx_q == 3'd6)
                            state_q <= S_PAY;
                    end
                end
                S_PAY: begin
                    if (accept) begin
                        pidx_q <= pidx_q + 10'd1;
                        if (rem_q > 9'd2) begin
                            rem_q <= rem_q - 9'd2;
                        end else begin
                            quart_q <= quart_q + 2'd1;
                            rem_q   <= (rem_q == 9'd2) ? qlen_q : qlen_q - 9'd1;
                        end
                    end
                end
                S_DRAIN: ;
                S_GAP: begin
                    if (gap_q != 8'd0)
                        gap_q <= gap_q - 8'd1;
                end
                default: state_q <= S_IDLE;
            endcase

            if (load) begin
                state_q <= S_HDR;
                len_q   <= len_eff;
                qlen_q  <= len_eff[10:2];
                rem_q   <= len_eff[10:2];
                quart_q <= '0;
                hidx_q  <= '0;
                pidx_q  <= '0;
                ferr_q  <= 1'b0;
            end
            if (go_drain)
                state_q <= S_DRAIN;
            if (finish) begin
                done_q <= done_d;
                ferr_q <= 1'b0;
                gap_q  <= gap_i;
                if (!(ferr_q || src_err_i))
                    sent_q <= sent_q + 32'd1;
                state_q <= (run_done || stop_q || stop_i) ? S_IDLE : S_GAP;
            end
        end
    end

    assign busy_o        = (state_q != S_IDLE);
    assign frames_sent_o = sent_q;
    assign err_o         = err_q;
    assign src_cyc_o     = cyc;
    assign src_stb_o     = stb;
    assign src_we_o      = cyc;
    assign src_sel_o     = 2'b11;
    assign src_adr_o     = 2'b00;
    assign src_dat_o     = dat;

endmodule
`default_nettype wire

// File: tb/tb_wrf_pkt_gen.sv
`default_nettype none
// tb_wrf_pkt_gen : directed frame vectors and multi-frame sequences for wrf_pkt_gen
module tb_wrf_pkt_gen;

    logic        clk = 1'b0;
    logic        rst_n, start_i, stop_i;
    logic [10:0] len_i;
    logic [15:0] nframes_i;
    logic [7:0]  gap_i;
    logic        busy_o, err_o;
    logic [31:0] frames_sent_o;
    logic        src_cyc_o, src_stb_o, src_we_o;
    logic [1:0]  src_sel_o, src_adr_o;
    logic [15:0] src_dat_o;
    logic        src_ack_i, src_stall_i, src_err_i;

    always #5 clk = ~clk;

    wrf_pkt_gen #(.g_min_len(64), .g_max_len(1500)) dut (
        .clk_sys_i(clk), .rst_n_i(rst_n), .start_i(start_i), .stop_i(stop_i),
        .len_i(len_i), .nframes_i(nframes_i), .gap_i(gap_i), .busy_o(busy_o),
        .frames_sent_o(frames_sent_o), .err_o(err_o), .src_cyc_o(src_cyc_o),
        .src_stb_o(src_stb_o), .src_we_o(src_we_o), .src_sel_o(src_sel_o),
        .src_adr_o(src_adr_o), .src_dat_o(src_dat_o), .src_ack_i(src_ack_i),
        .src_stall_i(src_stall_i), .src_err_i(src_err_i)
    );

    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic int clamp_len(input logic [10:0] l);
        int m;
        m = 32'(l) & 32'h7FC;
        if (m < 64) m = 64;
        if (m > 1500) m = 1500;
        return m;
    endfunction

    function automatic logic [15:0] model_word(input int len, input int i);
        int k, q;
        if (i < 3) return 16'hFFFF;
        if (i == 3) return 16'h0102;
        if (i == 4) return 16'h0304;
        if (i == 5) return 16'h0506;
        if (i == 6) return 16'(len);
        k = 2 * (i - 7);
        q = len / 4;
        return {8'(k / q), 8'((k + 1) / q)};
    endfunction

    // sink configuration (written by the main sequence between runs)
    int  stall_pct = 0, ack_lo = 1, ack_hi = 1;
    int  err_frame = -1, err_ack = 0;
    bit  rand_len = 1'b0;
    // sink observations
    logic [15:0] cur_words[$];
    logic [15:0] last_frame[$];
    int  due_q[$];
    int  cycle = 0, frame_no = 0, frames_seen = 0, ack_in_frame = 0;
    int  cur_L = 64, stb_cycles = 0, last_stb = 0;
    int  gap_run = 0, gap_min = 999, gap_max = 0;
    bit  gap_active = 1'b0, cyc_prev = 1'b0, frame_had_err = 1'b0, err_chk_pend = 1'b0;
    logic err_stb_after = 1'bx, err_o_after = 1'bx;

    task automatic check_frame();
        int n, bad;
        n = 7 + cur_L / 2;
        bad = -1;
        total++;
        if (cur_words.size() != n) begin
            $display("FAIL frame_len (frame %0d, L=%0d): got %0d words, expected %0d",
                     frame_no, cur_L, cur_words.size(), n);
            return;
        end
        for (int i = 0; i < n; i++)
            if (bad < 0 && cur_words[i] !== model_word(cur_L, i)) bad = i;
        if (bad >= 0)
            $display("FAIL frame_word (frame %0d, L=%0d, word %0d): got 0x%04h, expected 0x%04h",
                     frame_no, cur_L, bad, cur_words[bad], model_word(cur_L, bad));
        else
            passed++;
    endtask

    // Fabric sink: random stall, in-order acks after a random delay, optional error.
    initial begin
        int due;
        src_ack_i = 1'b0; src_err_i = 1'b0; src_stall_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (!rst_n) begin
                cur_words.delete(); due_q.delete();
                cyc_prev = 1'b0; gap_active = 1'b0;
                src_ack_i = 1'b0; src_err_i = 1'b0; src_stall_i = 1'b0;
            end else begin
                if (err_chk_pend) begin
                    err_stb_after = src_stb_o;
                    err_o_after   = err_o;
                    err_chk_pend  = 1'b0;
                end
                if (src_cyc_o && !cyc_prev) begin
                    frame_no++;
                    ack_in_frame = 0; frame_had_err = 1'b0; stb_cycles = 0;
                    cur_words.delete();
                    cur_L = clamp_len(len_i);
                    if (gap_active) begin
                        if (gap_run < gap_min) gap_min = gap_run;
                        if (gap_run > gap_max) gap_max = gap_run;
                        gap_active = 1'b0;
                    end
                end else if (!src_cyc_o && cyc_prev) begin
                    frames_seen++;
                    last_frame = cur_words;
                    last_stb = stb_cycles;
                    if (!frame_had_err) check_frame();
                    if (rand_len) len_i = 11'($urandom_range(128, 1500));
                    gap_active = 1'b1;
                    gap_run = 1;
                end else if (!src_cyc_o && gap_active) begin
                    gap_run++;
                end
                if (src_stb_o) stb_cycles++;

                src_ack_i = 1'b0; src_err_i = 1'b0;
                if (due_q.size() > 0 && due_q[0] == cycle) begin
                    void'(due_q.pop_front());
                    ack_in_frame++;
                    if (frame_no == err_frame && ack_in_frame == err_ack) begin
                        src_err_i = 1'b1; frame_had_err = 1'b1; err_chk_pend = 1'b1;
                    end else begin
                        src_ack_i = 1'b1;
                    end
                end
                src_stall_i = ($urandom_range(0, 99) < stall_pct);
                if (src_stb_o && !src_stall_i) begin
                    cur_words.push_back(src_dat_o);
                    due = cycle + $urandom_range(ack_lo, ack_hi);
                    if (due_q.size() > 0 && due <= due_q[$]) due = due_q[$] + 1;
                    due_q.push_back(due);
                end
                cyc_prev = src_cyc_o;
            end
        end
    end

    logic s_busy, s_cyc, s_stb, s_err;
    logic [15:0] s_dat;

    task automatic pulse_start();
        @(posedge clk); #2 start_i = 1'b1;
        @(posedge clk); #3;
        s_busy = busy_o; s_cyc = src_cyc_o; s_stb = src_stb_o; s_dat = src_dat_o; s_err = err_o;
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        do begin @(posedge clk); #3; n++; end while (busy_o && n < budget);
        chk({name, "_idle"}, 32'(busy_o), 32'd0);
    endtask

    task automatic wait_words(input int fno, input int cnt, input int budget, input string name);
        int n;
        n = 0;
        while (!(frame_no == fno && cur_words.size() >= cnt) && n < budget) begin
            @(posedge clk); #3; n++;
        end
        chk({name, "_reached"}, 32'(frame_no == fno && cur_words.size() >= cnt), 32'd1);
    endtask

    typedef struct {
        logic [10:0] len;
        int          idx;
        logic [15:0] val;
        int          words;
    } vec_t;
    vec_t vec [10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_sent;
        logic [15:0] pv;
        vec[0] = '{len: 11'd128,  idx: 6,   val: 16'h0080, words: 71};
        vec[1] = '{len: 11'd128,  idx: 22,  val: 16'h0000, words: 71};
        vec[2] = '{len: 11'd128,  idx: 23,  val: 16'h0101, words: 71};
        vec[3] = '{len: 11'd128,  idx: 70,  val: 16'h0303, words: 71};
        vec[4] = '{len: 11'd1502, idx: 6,   val: 16'h05DC, words: 757};
        vec[5] = '{len: 11'd1502, idx: 194, val: 16'h0001, words: 757};
        vec[6] = '{len: 11'd10,   idx: 6,   val: 16'h0040, words: 39};
        vec[7] = '{len: 11'd100,  idx: 19,  val: 16'h0001, words: 57};
        vec[8] = '{len: 11'd2047, idx: 6,   val: 16'h05DC, words: 757};
        vec[9] = '{len: 11'd67,   idx: 6,   val: 16'h0040, words: 39};

        rst_n = 1'b0; start_i = 1'b0; stop_i = 1'b0;
        len_i = 11'd128; nframes_i = 16'd1; gap_i = 8'd0;
        repeat (3) @(posedge clk);
        #3;
        chk("rst_cyc", 32'(src_cyc_o), 32'd0);
        chk("rst_stb", 32'(src_stb_o), 32'd0);
        chk("rst_we", 32'(src_we_o), 32'd0);
        chk("rst_dat", 32'(src_dat_o), 32'd0);
        chk("rst_adr", 32'(src_adr_o), 32'd0);
        chk("rst_sel", 32'(src_sel_o), 32'd3);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_sent", frames_sent_o, 32'd0);
        rst_n = 1'b1;
        exp_sent = 0;

        // single-frame vectors
        for (int t = 0; t < 10; t++) begin
            len_i = vec[t].len; nframes_i = 16'd1; gap_i = 8'd0;
            pulse_start();
            chk("start_busy", 32'(s_busy), 32'd1);
            chk("start_cyc", 32'(s_cyc), 32'd1);
            chk("start_stb", 32'(s_stb), 32'd1);
            chk("start_dat", 32'(s_dat), 32'hFFFF);
            wait_idle(3000, "vec");
            exp_sent++;
            pv = (vec[t].idx < last_frame.size()) ? last_frame[vec[t].idx] : 16'hxxxx;
            chk("vec_words", 32'(last_frame.size()), 32'(vec[t].words));
            chk("vec_stb_cycles", 32'(last_stb), 32'(vec[t].words));
            chk("vec_probe", 32'(pv), 32'(vec[t].val));
            chk("vec_sent", frames_sent_o, 32'(exp_sent));
        end

        // random stalls and ack delays, random lengths
        stall_pct = 50; ack_lo = 1; ack_hi = 3; rand_len = 1'b1;
        len_i = 11'($urandom_range(128, 1500)); nframes_i = 16'd20; gap_i = 8'd3;
        frames_seen = 0;
        pulse_start();
        wait_idle(60000, "rand");
        exp_sent += 20;
        rand_len = 1'b0;
        chk("rand_frames_seen", 32'(frames_seen), 32'd20);
        chk("rand_sent", frames_sent_o, 32'(exp_sent));

        // error on the 5th response of frame 2 of 3
        stall_pct = 0; ack_lo = 1; ack_hi = 2;
        len_i = 11'd64; nframes_i = 16'd3; gap_i = 8'd2;
        frame_no = 0; frames_seen = 0; err_frame = 2; err_ack = 5;
        pulse_start();
        wait_idle(3000, "err");
        err_frame = -1;
        exp_sent += 2;
        chk("err_stb_next", 32'(err_stb_after), 32'd0);
        chk("err_o_next", 32'(err_o_after), 32'd1);
        chk("err_frames_seen", 32'(frames_seen), 32'd3);
        chk("err_sent", frames_sent_o, 32'(exp_sent));
        chk("err_sticky", 32'(err_o), 32'd1);

        // continuous run stopped during frame 4
        ack_lo = 1; ack_hi = 1;
        len_i = 11'd64; nframes_i = 16'd0; gap_i = 8'd10;
        frame_no = 0; frames_seen = 0; gap_active = 1'b0; gap_min = 999; gap_max = 0;
        pulse_start();
        chk("cont_err_cleared", 32'(s_err), 32'd0);
        wait_words(4, 10, 3000, "cont");
        @(posedge clk); #2 stop_i = 1'b1;
        @(posedge clk); #3 stop_i = 1'b0;
        wait_idle(3000, "cont");
        exp_sent += 4;
        chk("cont_frames_seen", 32'(frames_seen), 32'd4);
        chk("cont_sent", frames_sent_o, 32'(exp_sent));
        chk("cont_gap_min", 32'(gap_min), 32'd11);
        chk("cont_gap_max", 32'(gap_max), 32'd11);

        // synchronous reset in PAY, then a clean frame
        len_i = 11'd128; nframes_i = 16'd1; gap_i = 8'd0;
        frame_no = 0;
        pulse_start();
        wait_words(1, 20, 500, "prst");
        @(posedge clk); #2 rst_n = 1'b0;
        @(posedge clk); #3;
        chk("prst_cyc", 32'(src_cyc_o), 32'd0);
        chk("prst_stb", 32'(src_stb_o), 32'd0);
        chk("prst_we", 32'(src_we_o), 32'd0);
        chk("prst_dat", 32'(src_dat_o), 32'd0);
        chk("prst_busy", 32'(busy_o), 32'd0);
        chk("prst_sent", frames_sent_o, 32'd0);
        rst_n = 1'b1;
        exp_sent = 0;
        pulse_start();
        wait_idle(3000, "prst");
        exp_sent++;
        chk("prst_words", 32'(last_frame.size()), 32'd71);
        chk("prst_sent_after", frames_sent_o, 32'(exp_sent));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
